// File: rtl/otter_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : otter_fetch_stage
// Purpose  : OTTER instruction-fetch stage; owns the PC and drives the memory
//            instruction port. Optional macro FETCH_PERF_CNT_EN adds the
//            fetch/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module otter_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        HALT_REQ,
    input  logic        RESUME,
`ifdef FETCH_PERF_CNT_EN
    input  logic        PERF_CLR,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_BUBBLES,
`endif
    output logic [13:0] MEM_ADDR1,
    output logic        MEM_RDEN1,
    output logic        FLUSH,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4,
    output logic        IF_VALID,
    output logic        MISALIGN,
    output logic        PC_OOB
);

    localparam logic [1:0]  c_st_boot   = 2'd0;
    localparam logic [1:0]  c_st_run    = 2'd1;
    localparam logic [1:0]  c_st_halt   = 2'd2;
    localparam logic [31:0] c_mem_limit = MEM_BYTES;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;
    logic        r_misalign;
    logic        w_fetch;
    logic        w_redirect;
    logic        w_bubble;

    // BOOT ignores redirects; RUN and HALT both accept them.
    assign w_redirect = BR_TAKEN & (r_state != c_st_boot);
    assign w_fetch    = (r_state == c_st_run) & ~BR_TAKEN & ~STALL;
    assign w_bubble   = (r_state != c_st_run) | w_redirect;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_boot: w_state_next = c_st_run;
            c_st_run: begin
                if (!BR_TAKEN && !STALL && HALT_REQ) begin
                    w_state_next = c_st_halt;
                end
            end
            c_st_halt: begin
                if (RESUME) begin
                    w_state_next = c_st_run;
                end
            end
            default: w_state_next = c_st_boot;
        endcase
    end

    always_comb begin
        MEM_RDEN1 = 1'b0;
        FLUSH     = 1'b1;
        case (r_state)
            c_st_run: begin
                MEM_RDEN1 = w_fetch;
                FLUSH     = BR_TAKEN;
            end
            default: begin
                MEM_RDEN1 = 1'b0;
                FLUSH     = 1'b1;
            end
        endcase
    end

    // A stall in RUN falls through every branch, so PC and IF metadata hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc       <= RESET_PC;
            r_if_pc    <= 32'd0;
            r_if_pc4   <= 32'd0;
            r_if_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (w_redirect) begin
                r_pc       <= {BR_TARGET[31:2], 2'b00};
                r_if_valid <= 1'b0;
                r_misalign <= |BR_TARGET[1:0];
            end else if (w_fetch) begin
                r_if_pc    <= r_pc;
                r_if_pc4   <= r_pc + 32'd4;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + 32'd4;
            end else if (r_state != c_st_run) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign MEM_ADDR1 = r_pc[15:2];
    assign PC_OOB    = (r_pc >= c_mem_limit);
    assign IF_PC     = r_if_pc;
    assign IF_PC4    = r_if_pc4;
    assign IF_VALID  = r_if_valid;
    assign MISALIGN  = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_fetched <= 32'd0;
            r_perf_bubbles <= 32'd0;
        end else if (PERF_CLR) begin
            r_perf_fetched <= 32'd0;
            r_perf_bubbles <= 32'd0;
        end else begin
            if (w_fetch && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_bubble && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign PERF_FETCHED = r_perf_fetched;
    assign PERF_BUBBLES = r_perf_bubbles;
`else
    logic w_unused_bubble;
    assign w_unused_bubble = w_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_fetch_stage
// Purpose  : Self-checking bench for otter_fetch_stage against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        STALL = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = 32'd0;
    logic        HALT_REQ = 1'b0;
    logic        RESUME = 1'b0;
    logic [13:0] MEM_ADDR1;
    logic        MEM_RDEN1;
    logic        FLUSH;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC4;
    logic        IF_VALID;
    logic        MISALIGN;
    logic        PC_OOB;
`ifdef FETCH_PERF_CNT_EN
    logic        PERF_CLR = 1'b0;
    logic [31:0] PERF_FETCHED;
    logic [31:0] PERF_BUBBLES;
`endif

    otter_fetch_stage #(.RESET_PC(RESET_PC), .MEM_BYTES(65536)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
        .BR_TARGET(BR_TARGET), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
`ifdef FETCH_PERF_CNT_EN
        .PERF_CLR(PERF_CLR), .PERF_FETCHED(PERF_FETCHED), .PERF_BUBBLES(PERF_BUBBLES),
`endif
        .MEM_ADDR1(MEM_ADDR1), .MEM_RDEN1(MEM_RDEN1), .FLUSH(FLUSH),
        .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_VALID(IF_VALID),
        .MISALIGN(MISALIGN), .PC_OOB(PC_OOB)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Architectural view: where fetch is, what the IF/ID side shows, and
    // whether the stage is in its boot bubble or parked.
    logic [31:0] m_pc, m_if_pc, m_if_pc4;
    bit          m_valid, m_mis, m_boot, m_halt;
    int unsigned m_fetched, m_bubbles;
    bit          perf_clr_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_if_pc = 0; m_if_pc4 = 0;
        m_valid = 0; m_mis = 0; m_boot = 1; m_halt = 0;
        m_fetched = 0; m_bubbles = 0;
    endtask

    // Called shortly after a rising edge: drive, check combinational outputs,
    // advance the model, then check registered outputs after the next edge.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt,
                        input bit hq, input bit rs);
        bit exp_fetch, exp_flush, bubble;
        STALL = st; BR_TAKEN = br; BR_TARGET = tgt; HALT_REQ = hq; RESUME = rs;
`ifdef FETCH_PERF_CNT_EN
        PERF_CLR = perf_clr_req;
`endif
        #1;
        exp_fetch = !m_boot && !m_halt && !br && !st;
        exp_flush = m_boot || m_halt || br;
        check("MEM_ADDR1", 32'(MEM_ADDR1), {18'd0, m_pc[15:2]});
        check("MEM_RDEN1", 32'(MEM_RDEN1), 32'(exp_fetch));
        check("FLUSH",     32'(FLUSH),     32'(exp_flush));
        check("PC_OOB",    32'(PC_OOB),    32'(m_pc >= 32'd65536));

        m_mis = 0;
        bubble = 0;
        if (m_boot) begin
            m_boot = 0; m_valid = 0; bubble = 1;
        end else if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_valid = 0; m_mis = (tgt[1:0] != 2'b00); bubble = 1;
            if (m_halt && rs) m_halt = 0;
        end else if (m_halt) begin
            m_valid = 0; bubble = 1;
            if (rs) m_halt = 0;
        end else if (!st) begin
            m_if_pc = m_pc; m_if_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
            if (hq) m_halt = 1;
        end
        if (perf_clr_req) begin
            m_fetched = 0; m_bubbles = 0;
        end else begin
            if (exp_fetch) m_fetched++;
            if (bubble) m_bubbles++;
        end

        @(posedge CLK);
        #1;
        check("IF_PC",    IF_PC,             m_if_pc);
        check("IF_PC4",   IF_PC4,            m_if_pc4);
        check("IF_VALID", 32'(IF_VALID),     32'(m_valid));
        check("MISALIGN", 32'(MISALIGN),     32'(m_mis));
`ifdef FETCH_PERF_CNT_EN
        check("PERF_FETCHED", PERF_FETCHED, m_fetched);
        check("PERF_BUBBLES", PERF_BUBBLES, m_bubbles);
`endif
    endtask

    // Asynchronous reset pulse taken mid-cycle while a redirect is requested.
    task automatic async_reset();
        STALL = 0; BR_TAKEN = 1; BR_TARGET = 32'h0000_0300; HALT_REQ = 1; RESUME = 0;
        #1 RST = 1;
        #1;
        check("RST_IF_VALID",  32'(IF_VALID),  32'd0);
        check("RST_IF_PC",     IF_PC,          32'd0);
        check("RST_IF_PC4",    IF_PC4,         32'd0);
        check("RST_MISALIGN",  32'(MISALIGN),  32'd0);
        check("RST_FLUSH",     32'(FLUSH),     32'd1);
        check("RST_MEM_RDEN1", 32'(MEM_RDEN1), 32'd0);
        check("RST_PC_OOB",    32'(PC_OOB),    32'd0);
        check("RST_MEM_ADDR1", 32'(MEM_ADDR1), {18'd0, RESET_PC[15:2]});
        @(posedge CLK);
        #2;
        BR_TAKEN = 0; HALT_REQ = 0;
        RST = 0;
        model_reset();
    endtask

    logic [31:0] rtgt;

    initial begin
        @(posedge CLK);
        #1;
        async_reset();

        step(0, 0, 0, 0, 0);                      // boot bubble
        repeat (4) step(0, 0, 0, 0, 0);           // IF_PC 0,4,8,C; PC now 0x10
        repeat (3) step(1, 0, 0, 0, 0);           // stall at PC=0x10
        repeat (2) step(0, 0, 0, 0, 0);           // IF_PC 0x10 then 0x14
        step(1, 1, 32'h0000_0200, 0, 0);          // redirect beats stall
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0103, 0, 0);          // misaligned target
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0020, 0, 0);
        step(0, 0, 0, 1, 0);                      // fetch 0x20, then halt
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);                      // resume
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 0, 0);          // wraparound and out-of-range PC
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);                      // halt waits for stall to drop
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h0000_0041, 0, 0);          // redirect while halted
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        async_reset();
        step(0, 0, 0, 0, 0);
        repeat (9) step(0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0080, 0, 0);
        step(0, 0, 0, 0, 0);                      // tenth fetch
`ifdef FETCH_PERF_CNT_EN
        check("PERF_FETCHED_10", PERF_FETCHED, 32'd10);
        check("PERF_BUBBLES_2",  PERF_BUBBLES, 32'd2);
        perf_clr_req = 1;
        step(0, 0, 0, 0, 0);
        perf_clr_req = 0;
`endif

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0: rtgt = $urandom;
                    1: rtgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: rtgt = 32'($urandom_range(0, 1023));
                endcase
                step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rtgt,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otter_fetch_stage.md
Name: otter_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage OTTER pipeline, directly upstream of the instruction port of the OTTER memory.
- Owns the PC and drives the memory's MEM_ADDR1, MEM_RDEN1 and FLUSH.
- Emits IF/ID-side metadata (PC, PC+4, valid) aligned with the synchronously-read instruction on MEM_DOUT1.
- Handles stall, branch/jump redirect, halt/resume and the post-reset boot bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- MEM_BYTES, 65536, instruction memory span in bytes; PC at or above this raises PC_OOB.

Ports:
- CLK  in  1  pipeline clock (same clock as MEM_CLK)
- RST  in  1  asynchronous, active-high reset
- STALL  in  1  hazard-unit stall; hold PC and the current instruction
- BR_TAKEN  in  1  redirect request from EX (branch/jal/jalr/trap)
- BR_TARGET  in  32  redirect byte address
- HALT_REQ  in  1  enter HALT after the current fetch
- RESUME  in  1  leave HALT
- MEM_ADDR1  out  14  word address to memory, = PC[15:2] (combinational)
- MEM_RDEN1  out  1  memory instruction read enable
- FLUSH  out  1  forces the memory to load 0 (nop) into MEM_DOUT1 at the next edge
- IF_PC  out  32  byte address of the instruction currently on MEM_DOUT1
- IF_PC4  out  32  IF_PC + 4
- IF_VALID  out  1  MEM_DOUT1 holds a real instruction
- MISALIGN  out  1  one-cycle pulse: BR_TARGET[1:0] != 0 was accepted
- PC_OOB  out  1  level: current PC >= MEM_BYTES

Behaviour:
- Reset (async, RST=1): PC=RESET_PC, IF_PC=0, IF_PC4=0, IF_VALID=0, MISALIGN=0, state=BOOT.
- During reset, combinational outputs are MEM_RDEN1=0, FLUSH=1, PC_OOB=0 (for a legal RESET_PC).
- Reset mid-operation aborts any redirect or halt immediately.
- States: BOOT, RUN, HALT.
- BOOT (exactly one cycle after RST falls):
  - MEM_RDEN1=0, FLUSH=1, PC held, IF_VALID<=0.
  - Next state RUN.
- RUN, normal (STALL=0, BR_TAKEN=0):
  - MEM_RDEN1=1, FLUSH=0.
  - At the edge: IF_PC<=PC, IF_PC4<=PC+4, IF_VALID<=1, PC<=PC+4.
  - Latency: instruction at PC appears on MEM_DOUT1 together with IF_PC one edge later.
- RUN, STALL=1, BR_TAKEN=0:
  - MEM_RDEN1=0, FLUSH=0.
  - PC, IF_PC, IF_PC4 and IF_VALID hold, so MEM_DOUT1 holds.
- RUN, BR_TAKEN=1 (wins over STALL and HALT_REQ):
  - FLUSH=1, MEM_RDEN1=0.
  - At the edge: PC<={BR_TARGET[31:2],2'b00}, IF_VALID<=0, MISALIGN<=|BR_TARGET[1:0].
  - Exactly one bubble; the target is fetched the following cycle.
- RUN, HALT_REQ=1, BR_TAKEN=0, STALL=0:
  - Performs that cycle's normal fetch, then state<=HALT.
- RUN, HALT_REQ=1 with STALL=1: the halt waits until STALL is low.
- HALT:
  - MEM_RDEN1=0, FLUSH=1 (nop), PC held, IF_VALID<=0.
  - RESUME=1 moves to RUN the next cycle and fetch restarts at the held PC.
  - BR_TAKEN in HALT updates PC (with the same MISALIGN rule) and stays in HALT unless RESUME is also high.
- MISALIGN is a single-cycle pulse and is cleared the cycle after it is set.
- PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- MEM_ADDR1 uses PC[15:2] only, so addresses alias within 64 KB; PC_OOB flags this and fetch continues.
- Priority: RST > BR_TAKEN > STALL > HALT_REQ > normal increment.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs PERF_FETCHED[31:0] (increments on each edge where IF_VALID<=1) and PERF_BUBBLES[31:0] (increments on each edge where IF_VALID<=0 outside reset).
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and cleared by input PERF_CLR (synchronous, lower priority than RST).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, no stall, RESET_PC=0 -> edge 1 IF_VALID=0 (BOOT); edges 2..4 IF_PC=0,4,8, IF_VALID=1, MEM_ADDR1 = 0,1,2 the cycle before each.
- STALL high for 3 cycles at PC=0x10 -> MEM_RDEN1=0; IF_PC, IF_VALID and MEM_ADDR1=4 constant for 3 cycles; then IF_PC=0x10 is followed by 0x14.
- BR_TAKEN with BR_TARGET=0x200 while STALL=1 -> FLUSH=1 that cycle; next IF_VALID=0; following IF_PC=0x200, IF_VALID=1, MISALIGN=0.
- BR_TAKEN with BR_TARGET=0x103 -> MISALIGN pulses one cycle; fetch resumes at IF_PC=0x100.
- HALT_REQ at PC=0x20 -> IF_PC=0x20 valid, then IF_VALID=0 and FLUSH=1 held; RESUME -> next IF_PC=0x24.
- RST pulsed asynchronously mid-redirect -> outputs reset immediately without a clock edge; BOOT bubble, then IF_PC=RESET_PC. With FETCH_PERF_CNT_EN: 10 fetches + 1 branch -> PERF_FETCHED=10, PERF_BUBBLES=2 (BOOT + flush).
